// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
//
// ID/EX pipeline register for the five-stage core. Sits between decode
// (register file read, immediate generation, control decode) and execute
// (ALU, forwarding muxes).
//
// Besides carrying the decoded instruction one stage forward it:
//   - tracks a per-stage valid bit,
//   - holds all contents while the EX/MEM side requests a stall,
//   - turns the EX slot into a bubble on a branch/jump flush,
//   - detects load-use hazards against the instruction already in EX and
//     inserts a bubble automatically while asking decode to hold,
//   - counts inserted bubbles in a saturating performance counter.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   stall_i             hold request from EX/MEM; every register keeps its value
//   flush_i             redirect; the instruction entering EX is killed
//   ValidD .. MEM_CtrlD decode-stage instruction (data, addresses, controls)
//   ValidE .. MEM_CtrlE registered copies presented to EX
//   load_use_stall_o    combinational; decode must hold IF/ID this cycle
//   bubble_count_o      bubbles inserted since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3,
    parameter int MEMC_W = 2,
    parameter int F3_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              stall_i,
    input  logic              flush_i,

    input  logic              ValidD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   SignImmD,
    input  logic [REG_AW-1:0] A3D,
    input  logic [REG_AW-1:0] RD1AddrD,
    input  logic [REG_AW-1:0] RD2AddrD,
    input  logic [F3_W-1:0]   funct3D,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              ALUSrcD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [MEMC_W-1:0] MEM_CtrlD,

    output logic              ValidE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   SignImmE,
    output logic [REG_AW-1:0] A3E,
    output logic [REG_AW-1:0] RD1AddrE,
    output logic [REG_AW-1:0] RD2AddrE,
    output logic [F3_W-1:0]   funct3E,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [MEMC_W-1:0] MEM_CtrlE,

    output logic              load_use_stall_o,
    output logic [CNT_W-1:0]  bubble_count_o
);

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    // A load in EX whose destination is read by the instruction in decode
    // cannot be forwarded in time. x0 is hard-wired to zero and a bubble in EX
    // produces nothing, so neither may raise a hazard.
    logic ex_is_load;
    logic src_match;
    logic hz;

    assign ex_is_load = ValidE & MemtoRegE & RegWriteE & (A3E != '0);
    assign src_match  = (RD1AddrD == A3E) | (RD2AddrD == A3E);
    assign hz         = ex_is_load & ValidD & src_match;

    // Decode only needs to hold when this edge actually resolves the hazard
    // with a bubble. A flush kills the dependent instruction anyway, and a
    // stall already freezes everything.
    assign load_use_stall_o = hz & ~flush_i & ~stall_i;

    // -------------------------------------------------------------------------
    // Edge action
    // -------------------------------------------------------------------------
    // Flush outranks stall; a hazard only acts on an unstalled edge.
    logic insert_bubble;
    logic capture;

    assign insert_bubble = flush_i | (~stall_i & hz);
    assign capture       = ~flush_i & ~stall_i & ~hz;

    // -------------------------------------------------------------------------
    // Control/valid registers: cleared by a bubble
    // -------------------------------------------------------------------------
    // Controls are gated with ValidD on capture so that every control output
    // reads zero whenever ValidE is zero; downstream stages can then use the
    // control bits alone to suppress side effects.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
            MEM_CtrlE   <= '0;
        end else if (insert_bubble) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
            MEM_CtrlE   <= '0;
        end else if (capture) begin
            ValidE      <= ValidD;
            RegWriteE   <= RegWriteD & ValidD;
            MemtoRegE   <= MemtoRegD & ValidD;
            MemWriteE   <= MemWriteD & ValidD;
            ALUSrcE     <= ALUSrcD & ValidD;
            ALUControlE <= ValidD ? ALUControlD : '0;
            MEM_CtrlE   <= ValidD ? MEM_CtrlD : '0;
        end
    end

    // -------------------------------------------------------------------------
    // Data/address registers: only loaded on a plain capture edge
    // -------------------------------------------------------------------------
    // A bubble leaves these untouched; they are don't-care once ValidE drops
    // and holding them avoids needless toggling of the wide operand buses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD1E     <= '0;
            RD2E     <= '0;
            SignImmE <= '0;
            A3E      <= '0;
            RD1AddrE <= '0;
            RD2AddrE <= '0;
            funct3E  <= '0;
        end else if (capture) begin
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            SignImmE <= SignImmD;
            A3E      <= A3D;
            RD1AddrE <= RD1AddrD;
            RD2AddrE <= RD2AddrD;
            funct3E  <= funct3D;
        end
    end

    // -------------------------------------------------------------------------
    // Bubble counter, saturating at all-ones
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_o <= '0;
        end else if (insert_bubble && (bubble_count_o != {CNT_W{1'b1}})) begin
            bubble_count_o <= bubble_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe
//
// Drives id_ex_pipe with directed and randomized instruction streams. A
// reference model of the EX slot is advanced once per cycle by the driver,
// which pushes the expected hazard output and the expected post-edge state
// into queues; two monitor processes pop and compare. A second instance with
// a 2-bit bubble counter shares all inputs to exercise saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int ALUC_W = 3;
    localparam int MEMC_W = 2;
    localparam int F3_W   = 3;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] a3;
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
        logic [F3_W-1:0]   f3;
        logic              rw;
        logic              m2r;
        logic              mw;
        logic              alusrc;
        logic [ALUC_W-1:0] aluc;
        logic [MEMC_W-1:0] memc;
    } instr_t;

    typedef struct {
        instr_t e;
        int     cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_i = 1'b1;
    logic flush_i = 1'b0;

    logic              ValidD;
    logic [XLEN-1:0]   RD1D, RD2D, SignImmD;
    logic [REG_AW-1:0] A3D, RD1AddrD, RD2AddrD;
    logic [F3_W-1:0]   funct3D;
    logic              RegWriteD, MemtoRegD, MemWriteD, ALUSrcD;
    logic [ALUC_W-1:0] ALUControlD;
    logic [MEMC_W-1:0] MEM_CtrlD;

    logic              ValidE, ValidE2;
    logic [XLEN-1:0]   RD1E, RD2E, SignImmE, RD1E2, RD2E2, SignImmE2;
    logic [REG_AW-1:0] A3E, RD1AddrE, RD2AddrE, A3E2, RD1AddrE2, RD2AddrE2;
    logic [F3_W-1:0]   funct3E, funct3E2;
    logic              RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
    logic              RegWriteE2, MemtoRegE2, MemWriteE2, ALUSrcE2;
    logic [ALUC_W-1:0] ALUControlE, ALUControlE2;
    logic [MEMC_W-1:0] MEM_CtrlE, MEM_CtrlE2;
    logic              load_use_stall_o, load_use_stall_o2;
    logic [15:0]       bubble_count_o;
    logic [1:0]        bubble_count_o2;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .A3D(A3D), .RD1AddrD(RD1AddrD), .RD2AddrD(RD2AddrD), .funct3D(funct3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .MEM_CtrlD(MEM_CtrlD),
        .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .A3E(A3E), .RD1AddrE(RD1AddrE), .RD2AddrE(RD2AddrE), .funct3E(funct3E),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MEM_CtrlE(MEM_CtrlE),
        .load_use_stall_o(load_use_stall_o), .bubble_count_o(bubble_count_o)
    );

    id_ex_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .A3D(A3D), .RD1AddrD(RD1AddrD), .RD2AddrD(RD2AddrD), .funct3D(funct3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .MEM_CtrlD(MEM_CtrlD),
        .ValidE(ValidE2), .RD1E(RD1E2), .RD2E(RD2E2), .SignImmE(SignImmE2),
        .A3E(A3E2), .RD1AddrE(RD1AddrE2), .RD2AddrE(RD2AddrE2), .funct3E(funct3E2),
        .RegWriteE(RegWriteE2), .MemtoRegE(MemtoRegE2), .MemWriteE(MemWriteE2),
        .ALUSrcE(ALUSrcE2), .ALUControlE(ALUControlE2), .MEM_CtrlE(MEM_CtrlE2),
        .load_use_stall_o(load_use_stall_o2), .bubble_count_o(bubble_count_o2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t snap_main();
        return '{ValidE, RD1E, RD2E, SignImmE, A3E, RD1AddrE, RD2AddrE, funct3E,
                 RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE, MEM_CtrlE};
    endfunction

    function automatic instr_t snap_sat();
        return '{ValidE2, RD1E2, RD2E2, SignImmE2, A3E2, RD1AddrE2, RD2AddrE2, funct3E2,
                 RegWriteE2, MemtoRegE2, MemWriteE2, ALUSrcE2, ALUControlE2, MEM_CtrlE2};
    endfunction

    // ---------------------------------------------------------------------
    // Reference model: the instruction sitting in EX plus a bubble tally
    // ---------------------------------------------------------------------
    instr_t m_e;
    int     m_cnt;
    bit     stall_q[$];
    exp_t   exp_q[$];

    // A bubble keeps the operands but carries no valid bit and no controls.
    function automatic instr_t as_bubble(input instr_t e);
        instr_t b = e;
        b.valid = 1'b0; b.rw = 1'b0; b.m2r = 1'b0; b.mw = 1'b0;
        b.alusrc = 1'b0; b.aluc = '0; b.memc = '0;
        return b;
    endfunction

    // Load in EX writing a nonzero register that decode wants to read.
    function automatic bit model_hazard(input instr_t ex, input instr_t d);
        if (!(ex.valid && ex.m2r && ex.rw) || ex.a3 == 0 || !d.valid) return 1'b0;
        return (d.ra1 == ex.a3) || (d.ra2 == ex.a3);
    endfunction

    // Called at a falling edge: drive one cycle of inputs, record expectations,
    // advance the model, and return at the next falling edge.
    task automatic cycle(input instr_t d, input bit st, input bit fl);
        bit hz;
        exp_t x;
        ValidD = d.valid; RD1D = d.rd1; RD2D = d.rd2; SignImmD = d.imm;
        A3D = d.a3; RD1AddrD = d.ra1; RD2AddrD = d.ra2; funct3D = d.f3;
        RegWriteD = d.rw; MemtoRegD = d.m2r; MemWriteD = d.mw; ALUSrcD = d.alusrc;
        ALUControlD = d.aluc; MEM_CtrlD = d.memc;
        stall_i = st; flush_i = fl;

        hz = model_hazard(m_e, d);
        stall_q.push_back(hz && !fl && !st);

        if (fl || (hz && !st)) begin
            m_e = as_bubble(m_e);
            m_cnt++;
        end else if (!st) begin
            m_e = d.valid ? d : as_bubble(d);
        end
        x.e = m_e;
        x.cnt = m_cnt;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // Called at a falling edge; the following rising edge is a stall edge so
    // nothing moves before the next cycle() call.
    task automatic reset_pulse();
        ValidD = 1'b1; RD1D = '1; RD2D = '1; SignImmD = '1; A3D = '1;
        RD1AddrD = '1; RD2AddrD = '1; funct3D = '1; RegWriteD = 1'b1;
        MemtoRegD = 1'b1; MemWriteD = 1'b1; ALUSrcD = 1'b1; ALUControlD = '1;
        MEM_CtrlD = '1; stall_i = 1'b1; flush_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("reset_state", 128'(snap_main()), 128'(0));
        check("reset_state_sat", 128'(snap_sat()), 128'(0));
        check("reset_count", 128'(bubble_count_o), 128'(0));
        check("reset_count_sat", 128'(bubble_count_o2), 128'(0));
        rst_n = 1'b1;
        m_e = '0;
        m_cnt = 0;
        @(negedge clk);
    endtask

    function automatic instr_t rand_instr();
        instr_t d;
        d.valid  = ($urandom_range(0, 7) != 0);
        d.rd1    = $urandom;
        d.rd2    = $urandom;
        d.imm    = $urandom;
        d.a3     = REG_AW'($urandom_range(0, 3));
        d.ra1    = REG_AW'($urandom_range(0, 3));
        d.ra2    = REG_AW'($urandom_range(0, 3));
        d.f3     = F3_W'($urandom);
        d.rw     = ($urandom_range(0, 3) != 0);
        d.m2r    = $urandom_range(0, 1);
        d.mw     = $urandom_range(0, 1);
        d.alusrc = $urandom_range(0, 1);
        d.aluc   = ALUC_W'($urandom);
        d.memc   = MEMC_W'($urandom);
        return d;
    endfunction

    // ---------------------------------------------------------------------
    // Monitors
    // ---------------------------------------------------------------------
    initial begin : mon_stall
        bit e;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                e = stall_q.pop_front();
                check("load_use_stall", 128'(load_use_stall_o), 128'(e));
                check("load_use_stall_sat", 128'(load_use_stall_o2), 128'(e));
            end
        end
    end

    initial begin : mon_state
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("ex_state", 128'(snap_main()), 128'(x.e));
                check("ex_state_sat", 128'(snap_sat()), 128'(x.e));
                check("bubble_count", 128'(bubble_count_o), 128'(x.cnt > 65535 ? 65535 : x.cnt));
                check("bubble_count_sat", 128'(bubble_count_o2), 128'(x.cnt > 3 ? 3 : x.cnt));
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin : stim
        instr_t d;
        instr_t nop;
        int waited;

        nop = '0;
        m_e = '0;
        m_cnt = 0;
        @(negedge clk);
        reset_pulse();

        // Passthrough
        d = '0;
        d.valid = 1'b1; d.rd1 = 32'hDEADBEEF; d.a3 = 5'd7; d.aluc = 3'b101; d.rw = 1'b1;
        cycle(d, 1'b0, 1'b0);
        check("pass_valid", 128'(ValidE), 128'(1));
        check("pass_rd1", 128'(RD1E), 128'(32'hDEADBEEF));
        check("pass_a3", 128'(A3E), 128'(7));
        check("pass_aluc", 128'(ALUControlE), 128'(3'b101));

        // Load-use on rs2: one bubble, then the held instruction enters EX
        d = '0;
        d.valid = 1'b1; d.a3 = 5'd5; d.m2r = 1'b1; d.rw = 1'b1; d.memc = 2'd2;
        cycle(d, 1'b0, 1'b0);
        d = '0;
        d.valid = 1'b1; d.ra2 = 5'd5; d.ra1 = 5'd3; d.a3 = 5'd6; d.rw = 1'b1; d.aluc = 3'd2;
        cycle(d, 1'b0, 1'b0);
        check("lu_bubble_valid", 128'(ValidE), 128'(0));
        check("lu_bubble_ctrl", 128'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE, MEM_CtrlE}), 128'(0));
        check("lu_bubble_count", 128'(bubble_count_o), 128'(1));
        cycle(d, 1'b0, 1'b0);
        check("lu_capture_valid", 128'(ValidE), 128'(1));
        check("lu_capture_ra2", 128'(RD2AddrE), 128'(5));

        // Load to x0 never stalls
        d = '0;
        d.valid = 1'b1; d.a3 = 5'd0; d.m2r = 1'b1; d.rw = 1'b1;
        cycle(d, 1'b0, 1'b0);
        d = '0;
        d.valid = 1'b1; d.ra1 = 5'd0; d.a3 = 5'd12; d.rd1 = 32'h0000_1234;
        cycle(d, 1'b0, 1'b0);
        check("x0_capture_a3", 128'(A3E), 128'(12));
        check("x0_count", 128'(bubble_count_o), 128'(1));

        // Three stalled edges with changing inputs
        for (int i = 0; i < 3; i++) begin
            cycle(rand_instr(), 1'b1, 1'b0);
            check("stall_hold_a3", 128'(A3E), 128'(12));
            check("stall_hold_rd1", 128'(RD1E), 128'(32'h0000_1234));
        end
        check("stall_count", 128'(bubble_count_o), 128'(1));

        // Flush + stall + hazard together: a single counted bubble
        d = '0;
        d.valid = 1'b1; d.a3 = 5'd9; d.ra1 = 5'd4; d.m2r = 1'b1; d.rw = 1'b1;
        cycle(d, 1'b0, 1'b0);
        d = '0;
        d.valid = 1'b1; d.ra1 = 5'd9; d.ra2 = 5'd1; d.rw = 1'b1;
        cycle(d, 1'b1, 1'b1);
        check("flush_valid", 128'(ValidE), 128'(0));
        check("flush_hold_ra1", 128'(RD1AddrE), 128'(4));
        check("flush_count", 128'(bubble_count_o), 128'(2));

        // Five flushes: the 2-bit counter pins at 3
        for (int i = 0; i < 5; i++) cycle(rand_instr(), 1'($urandom_range(0, 1)), 1'b1);
        check("sat_count", 128'(bubble_count_o2), 128'(3));
        check("wide_count", 128'(bubble_count_o), 128'(7));

        // Randomized traffic with a reset partway through
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_pulse();
            cycle(rand_instr(), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
        end
        cycle(nop, 1'b0, 1'b0);

        waited = 0;
        while ((exp_q.size() > 0 || stall_q.size() > 0) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0 || stall_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d/%0d entries left, required 0", exp_q.size(), stall_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline register for the five-stage core, between the decode stage (register file read, immediate generation, control decode) and the execute stage (ALU, forwarding muxes).
- Adds a per-stage valid bit, downstream stall (hold), flush (bubble insertion) and built-in load-use hazard detection with automatic bubble insertion.
- Adds a saturating bubble counter for performance monitoring.
- All datapath widths are set by parameters, so the same block serves RV32 and RV64 builds.

## Interface
Parameters:
- XLEN, 32, width of register operands and immediate
- REG_AW, 5, register address width
- ALUC_W, 3, ALU control width
- MEMC_W, 2, memory control width
- F3_W, 3, funct3 width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold request from EX/MEM side; registers keep contents
- flush_i  in  1  branch/jump redirect; kill instruction entering EX
- ValidD  in  1  decode stage holds a real instruction
- RD1D, RD2D  in  XLEN each  register file read data
- SignImmD  in  XLEN  sign-extended immediate
- A3D, RD1AddrD, RD2AddrD  in  REG_AW each  destination and source register addresses
- funct3D  in  F3_W  funct3 passthrough
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD  in  1 each  control bits
- ALUControlD  in  ALUC_W  ALU operation
- MEM_CtrlD  in  MEMC_W  memory access size/type
- ValidE, RD1E, RD2E, SignImmE, A3E, RD1AddrE, RD2AddrE, funct3E, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE, MEM_CtrlE  out  matching widths  registered copies for EX
- load_use_stall_o  out  1  combinational; decode must hold IF/ID this cycle
- bubble_count_o  out  CNT_W  number of bubbles inserted since reset, saturating

## Operation
Hazard term:
- hz = ValidE & MemtoRegE & RegWriteE & (A3E != 0) & ValidD & ((RD1AddrD == A3E) | (RD2AddrD == A3E))
- load_use_stall_o = hz & ~flush_i & ~stall_i

Per-edge action, first match in this priority order:
1. rst_n low (asynchronous): every output register cleared to 0; bubble_count_o = 0.
2. flush_i = 1: bubble. ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE and MEM_CtrlE are cleared; data/address fields (RD1E, RD2E, SignImmE, A3E, RD1AddrE, RD2AddrE, funct3E) hold. Flush overrides stall.
3. stall_i = 1: all registers hold; no bubble is counted.
4. hz = 1: bubble, with the same clearing as flush. Decode holds because load_use_stall_o = 1.
5. Otherwise: capture every D input into its E register.

Bubble counter:
- Increments by 1 on each edge where rule 2 or rule 4 applies.
- Saturates at 2^CNT_W−1; no wrap.

Additional rules:
- Register 0 never causes a hazard.
- A bubble in EX (ValidE = 0) never causes a hazard.
- Control outputs are zero whenever ValidE = 0, so downstream stages may ignore ValidE for side-effect suppression.

## Timing
- Latency: 1 cycle D→E when neither stall nor hazard is active.
- load_use_stall_o is purely combinational from current E registers and D inputs, with no registered delay.
- A load-use hazard costs exactly one bubble. On the next edge ValidE = 0, so hz drops and the held instruction is captured one cycle later.
- stall_i held for N cycles holds contents for N edges. A hazard pending during the stall is resolved on the first unstalled edge.
- flush_i together with hz: flush wins. One bubble is inserted and counted once; load_use_stall_o = 0.
- flush_i together with stall_i: flush wins and the bubble is counted.
- rst_n deassertion mid-stream: the first rising edge after release behaves per the priority rules using the cleared state, so ValidE = 0 and hz = 0.

## Test plan
- Reset: drive all D inputs to 1s and pulse rst_n low between edges → all E outputs and bubble_count_o read 0 immediately, without waiting for an edge.
- Passthrough: ValidD = 1, RD1D = 0xDEADBEEF, A3D = 7, ALUControlD = 3'b101 → after one edge E outputs match; load_use_stall_o = 0.
- Load-use: EX holds a load (MemtoRegE = RegWriteE = ValidE = 1, A3E = 5); decode has RD2AddrD = 5 →
  - load_use_stall_o = 1;
  - next edge gives ValidE = 0, control fields 0, bubble_count_o = 1;
  - the following edge captures the held instruction.
- A3E = 0 load with RD1AddrD = 0 → no stall; instruction captured.
- Stall: stall_i = 1 for 3 cycles with changing D inputs → E outputs unchanged for 3 edges; bubble_count_o unchanged.
- Flush priority and saturation:
  - flush_i = stall_i = 1 with a hazard present → one bubble, count +1, load_use_stall_o = 0;
  - with CNT_W = 2, five flushes → bubble_count_o = 3.
